// File: rtl/sequence_checker.sv
// rtl/sequence_checker.sv - aligns to the AF,BC,E2,78,FF,E2,0B,8D generator pattern
// and reports lock, per-byte errors and saturating sequence/error counts.
module sequence_checker #(
    parameter int CNT_W      = 16,
    parameter int MISS_LIMIT = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid,
    input  logic [7:0]       data_in,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [7:0]       exp_data,
    output logic [CNT_W-1:0] seq_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    function automatic logic [7:0] rom(input logic [2:0] i);
        case (i)
            3'd0:    rom = 8'hAF;
            3'd1:    rom = 8'hBC;
            3'd2:    rom = 8'hE2;
            3'd3:    rom = 8'h78;
            3'd4:    rom = 8'hFF;
            3'd5:    rom = 8'hE2;
            3'd6:    rom = 8'h0B;
            default: rom = 8'h8D;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [3:0]       miss_q, miss_d;
    logic             clean_q, clean_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [7:0]       exp_q, exp_d;
    logic [CNT_W-1:0] seq_q, seq_d;
    logic [CNT_W-1:0] errc_q, errc_d;
    logic             seq_inc, err_inc, match;
    logic [4:0]       miss_nx;

    assign match   = (data_in == rom(idx_q));
    assign miss_nx = {1'b0, miss_q} + 5'd1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        miss_d  = miss_q;
        clean_d = clean_q;
        err_d   = 1'b0;
        seq_inc = 1'b0;
        err_inc = 1'b0;
        if (valid) begin
            case (state_q)
                SEARCH: begin
                    if (data_in == 8'hAF) begin
                        state_d = ACQUIRE;
                        idx_d   = 3'd1;
                    end
                end
                ACQUIRE: begin
                    if (match) begin
                        idx_d = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_d = LOCKED;
                            seq_inc = 1'b1;
                            clean_d = 1'b1;
                            miss_d  = 4'd0;
                        end
                    end else if (data_in == 8'hAF) begin
                        idx_d = 3'd1;
                    end else begin
                        state_d = SEARCH;
                        idx_d   = 3'd0;
                    end
                end
                LOCKED: begin
                    // idx advances on every byte so alignment survives corrupted bytes
                    idx_d   = idx_q + 3'd1;
                    clean_d = (idx_q == 3'd7) ? 1'b1 : (clean_q & match);
                    if (match) begin
                        miss_d  = 4'd0;
                        seq_inc = (idx_q == 3'd7) && clean_q;
                    end else begin
                        err_d   = 1'b1;
                        err_inc = 1'b1;
                        if (miss_nx >= 5'(MISS_LIMIT)) begin
                            state_d = SEARCH;
                            idx_d   = 3'd0;
                            miss_d  = 4'd0;
                        end else begin
                            miss_d = miss_nx[3:0];
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                    idx_d   = 3'd0;
                end
            endcase
        end
        locked_d = (state_d == LOCKED);
        exp_d    = (state_d == SEARCH) ? 8'hAF : rom(idx_d);
        // clear has priority over a coincident count event
        seq_d  = clear ? '0 : ((seq_inc && (seq_q != '1)) ? seq_q + 1'b1 : seq_q);
        errc_d = clear ? '0 : ((err_inc && (errc_q != '1)) ? errc_q + 1'b1 : errc_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= SEARCH;
            idx_q    <= 3'd0;
            miss_q   <= 4'd0;
            clean_q  <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            exp_q    <= 8'hAF;
            seq_q    <= '0;
            errc_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            miss_q   <= miss_d;
            clean_q  <= clean_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            exp_q    <= exp_d;
            seq_q    <= seq_d;
            errc_q   <= errc_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_q;
    assign exp_data  = exp_q;
    assign seq_count = seq_q;
    assign err_count = errc_q;

endmodule

// File: tb/tb_sequence_checker.sv
// tb/tb_sequence_checker.sv - directed vector bench for sequence_checker.
module tb_sequence_checker;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        clear = 1'b0;
    logic        locked, err_pulse, locked4, err_pulse4;
    logic [7:0]  exp_data, exp_data4;
    logic [15:0] seq_count, err_count;
    logic [3:0]  seq_count4, err_count4;

    always #5 clk = ~clk;

    sequence_checker #(.CNT_W(16), .MISS_LIMIT(3)) dut (
        .clk(clk), .reset_n(reset_n), .valid(valid), .data_in(data_in), .clear(clear),
        .locked(locked), .err_pulse(err_pulse), .exp_data(exp_data),
        .seq_count(seq_count), .err_count(err_count));

    sequence_checker #(.CNT_W(4), .MISS_LIMIT(3)) dut4 (
        .clk(clk), .reset_n(reset_n), .valid(valid), .data_in(data_in), .clear(clear),
        .locked(locked4), .err_pulse(err_pulse4), .exp_data(exp_data4),
        .seq_count(seq_count4), .err_count(err_count4));

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       c;
        logic       lk;
        logic       ep;
        logic [7:0] ex;
        int         sq;
        int         er;
    } vec_t;

    vec_t       vecs [0:255];
    int         nvec = 0;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] pat [0:7];

    task automatic chk(input string name, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic c, input logic lk,
                       input logic ep, input logic [7:0] ex, input int sq, input int er);
        vecs[nvec] = '{v, d, c, lk, ep, ex, sq, er};
        nvec++;
    endtask

    // clean pattern pass; acq=1 means the pass starts outside LOCKED
    task automatic add_pass(input bit acq, input int sq, input int er);
        for (int k = 0; k < 8; k++)
            add(1'b1, pat[k], 1'b0, acq ? (k == 7) : 1'b1, 1'b0, pat[(k + 1) % 8],
                (k == 7) ? sq + 1 : sq, er);
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic c);
        valid = v; data_in = d; clear = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        pat[0] = 8'hAF; pat[1] = 8'hBC; pat[2] = 8'hE2; pat[3] = 8'h78;
        pat[4] = 8'hFF; pat[5] = 8'hE2; pat[6] = 8'h0B; pat[7] = 8'h8D;

        // mid-pattern start: FF,E2,0B,8D ignored in SEARCH, then acquire
        for (int k = 4; k < 8; k++) add(1'b1, pat[k], 1'b0, 1'b0, 1'b0, 8'hAF, 0, 0);
        add_pass(1'b1, 0, 0);
        // clean pass with valid toggling; idle bytes carry misleading data
        for (int k = 0; k < 8; k++) begin
            add(1'b1, pat[k], 1'b0, 1'b1, 1'b0, pat[(k + 1) % 8], (k == 7) ? 2 : 1, 0);
            add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, pat[(k + 1) % 8], (k == 7) ? 2 : 1, 0);
        end
        // 78 corrupted: one error, pass not counted
        add(1'b1, 8'hAF, 1'b0, 1'b1, 1'b0, 8'hBC, 2, 0);
        add(1'b1, 8'hBC, 1'b0, 1'b1, 1'b0, 8'hE2, 2, 0);
        add(1'b1, 8'hE2, 1'b0, 1'b1, 1'b0, 8'h78, 2, 0);
        add(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFF, 2, 1);
        add(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 8'hE2, 2, 1);
        add(1'b1, 8'hE2, 1'b0, 1'b1, 1'b0, 8'h0B, 2, 1);
        add(1'b1, 8'h0B, 1'b0, 1'b1, 1'b0, 8'h8D, 2, 1);
        add(1'b1, 8'h8D, 1'b0, 1'b1, 1'b0, 8'hAF, 2, 1);
        add_pass(1'b0, 2, 1);
        // three consecutive bad bytes drop lock on the third
        add(1'b1, 8'hAF, 1'b0, 1'b1, 1'b0, 8'hBC, 3, 1);
        add(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'hE2, 3, 2);
        add(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h78, 3, 3);
        add(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'hAF, 3, 4);
        for (int k = 4; k < 8; k++) add(1'b1, pat[k], 1'b0, 1'b0, 1'b0, 8'hAF, 3, 4);
        add_pass(1'b1, 3, 4);
        for (int p = 0; p < 16; p++) add_pass(1'b0, 4 + p, 4);

        // reset state
        #12;
        chk("rst_locked", int'(locked), 0);
        chk("rst_err_pulse", int'(err_pulse), 0);
        chk("rst_exp_data", int'(exp_data), 8'hAF);
        chk("rst_seq", int'(seq_count), 0);
        chk("rst_err", int'(err_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 8'h00, 1'b0);

        for (int i = 0; i < nvec; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].c);
            chk($sformatf("v%0d_locked", i), int'(locked), int'(vecs[i].lk));
            chk($sformatf("v%0d_err_pulse", i), int'(err_pulse), int'(vecs[i].ep));
            chk($sformatf("v%0d_exp_data", i), int'(exp_data), int'(vecs[i].ex));
            chk($sformatf("v%0d_seq", i), int'(seq_count), vecs[i].sq);
            chk($sformatf("v%0d_err", i), int'(err_count), vecs[i].er);
        end

        // 20 counted passes: narrow counter holds at 15
        chk("sat_seq4", int'(seq_count4), 15);
        chk("sat_err4", int'(err_count4), 4);
        chk("sat_seq16", int'(seq_count), 20);

        // asynchronous reset mid-pass
        step(1'b1, 8'hAF, 1'b0);
        step(1'b1, 8'hBC, 1'b0);
        chk("pre_rst_exp", int'(exp_data), 8'hE2);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_locked", int'(locked), 0);
        chk("mid_rst_exp", int'(exp_data), 8'hAF);
        chk("mid_rst_seq", int'(seq_count), 0);
        chk("mid_rst_err", int'(err_count), 0);
        chk("mid_rst_seq4", int'(seq_count4), 0);
        @(negedge clk);
        reset_n = 1'b1;
        // tail of the interrupted pass must not relock
        for (int k = 2; k < 8; k++) step(1'b1, pat[k], 1'b0);
        chk("tail_locked", int'(locked), 0);
        chk("tail_exp", int'(exp_data), 8'hAF);

        // AF during ACQUIRE restarts at idx 1
        step(1'b1, 8'hAF, 1'b0);
        step(1'b1, 8'hBC, 1'b0);
        step(1'b1, 8'hAF, 1'b0);
        chk("restart_exp", int'(exp_data), 8'hBC);
        chk("restart_locked", int'(locked), 0);
        for (int k = 1; k < 8; k++) step(1'b1, pat[k], 1'b0);
        chk("restart_lock", int'(locked), 1);
        chk("restart_seq", int'(seq_count), 1);

        // clear coinciding with a pass completion wins
        for (int k = 0; k < 7; k++) step(1'b1, pat[k], 1'b0);
        step(1'b1, pat[7], 1'b1);
        chk("clr_seq", int'(seq_count), 0);
        chk("clr_seq4", int'(seq_count4), 0);
        chk("clr_locked", int'(locked), 1);
        step(1'b0, 8'h00, 1'b0);
        chk("clr_hold_seq", int'(seq_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sequence_checker.md
Name: sequence_checker

Overview:
Downstream consumer of the 8-bit sequence generator output. It monitors the byte stream qualified by the generator's enable and aligns to the fixed 8-byte pattern AF,BC,E2,78,FF,E2,0B,8D. It then reports lock status, a per-byte error pulse, a completed-sequence count and an error count. It is the bench-side and on-chip integrity monitor for the generator.

Parameters:
CNT_W, 16, width of seq_count and err_count (saturating).
MISS_LIMIT, 3, consecutive mismatches in LOCKED that force loss of lock (range 1..15).

Ports:
clk  input  1  system clock, all logic on rising edge.
reset_n  input  1  asynchronous active-low reset.
valid  input  1  byte qualifier, driven by the generator's enable; data_in is sampled only when valid=1.
data_in  input  8  byte stream from the generator.
clear  input  1  synchronous clear of seq_count and err_count.
locked  output  1  1 while in LOCKED state.
err_pulse  output  1  one-cycle pulse for each mismatching valid byte while LOCKED.
exp_data  output  8  pattern byte expected at the next valid sample; 8'hAF outside LOCKED/ACQUIRE.
seq_count  output  CNT_W  number of complete 8-byte sequences verified, saturating.
err_count  output  CNT_W  number of err_pulse events, saturating.

Behaviour:
- Pattern ROM, index 0..7: AF,BC,E2,78,FF,E2,0B,8D. idx is a 3-bit pointer that wraps 7->0.
- Reset (asynchronous, reset_n=0): state=SEARCH, idx=0, miss=0, locked=0, err_pulse=0, exp_data=8'hAF, seq_count=0, err_count=0.
- All outputs are registered. The response to a valid byte appears in the cycle after it is sampled.
- When valid=0: state, idx, miss and counters hold; err_pulse=0.
- SEARCH:
  - Valid byte == 8'hAF -> ACQUIRE, idx=1.
  - Any other valid byte -> stay in SEARCH.
- ACQUIRE:
  - Valid byte == ROM[idx]: idx++.
  - If idx was 7 when the match occurred -> LOCKED, idx=0, seq_count++. locked rises the cycle after the 8D byte.
  - Mismatch: if the byte == 8'hAF -> remain in ACQUIRE with idx=1 (restart). Otherwise -> SEARCH, idx=0.
  - No err_pulse or err_count change in ACQUIRE.
- LOCKED:
  - Every valid byte advances idx, whether it matches or not, so alignment is kept through corrupted bytes.
  - Match: miss=0. If idx was 7 and the whole 8-byte window had no mismatch -> seq_count++.
  - Mismatch: err_pulse=1 for one cycle, err_count++, miss++.
  - If miss reaches MISS_LIMIT -> SEARCH, idx=0, miss=0, locked=0 in the following cycle.
  - The error on the byte that causes loss of lock still pulses and counts.
- exp_data = ROM[idx] in ACQUIRE and LOCKED; 8'hAF in SEARCH.
- Counters saturate at all-ones and never wrap.
- clear=1 zeroes both counters that cycle. If clear coincides with a count event, clear wins and the event is not counted. clear does not affect state, idx, locked or err_pulse.
- A repeated byte value (E2 at idx 2 and 5) carries no special meaning. Alignment is always by idx, not by value search.
- reset_n asserted mid-operation returns everything to reset values immediately. After release the checker needs a fresh AF..8D pass to relock.

Test Plan:
- Clean stream, valid=1 continuously, from AF: locked=1 the cycle after the 8th byte. seq_count reaches 4 after 32 bytes. err_count=0, err_pulse never asserted.
- Stream starting at FF (mid-pattern): stays in SEARCH until the next AF. Lock follows 8 bytes after that AF. No errors counted.
- Locked, one byte corrupted (the 78 in one pass replaced by 00): one err_pulse, err_count=1, locked stays 1. That pass is not added to seq_count; the next clean pass is.
- Locked, three consecutive corrupted bytes with MISS_LIMIT=3: err_count=3. locked drops the cycle after the 3rd bad byte, then relocks after the next full AF..8D pass.
- valid toggled 1,0,1,0 across a clean stream: same lock and count results as continuous valid. Nothing changes on valid=0 cycles.
- CNT_W=4, 20 clean passes: seq_count holds at 15. clear pulsed on the same cycle as a pass completion -> seq_count=0. reset_n pulsed mid-stream -> locked=0 and counters 0 immediately.
